mult_div_unit: RTL



---
 rtl/mult_div_unit.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO pair, plus MTHI/MTLO writes.
// Latency: start accepted at E0, busy for 32 cycles, done pulse and new HI/LO after E32.
// Backpressure: start and moves are ignored while busy; a new op may be accepted in the done cycle.
module mult_div_unit #(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            mthi_i,
  input  logic            mtlo_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  localparam int CW = $clog2(ITER);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t                state_q;
  logic [CW-1:0]         cnt_q;
  logic                  is_div_q;
  logic                  neg_lo_q;   // negate full product (mult) or quotient (div)
  logic                  neg_hi_q;   // negate remainder (signed div, negative dividend)
  logic [XLEN-1:0]       m_q;        // multiplicand or divisor magnitude
  logic [2*XLEN-1:0]     w_q;        // {partial product, multiplier} or {remainder, quotient}
  logic [2*XLEN-1:0]     w_d;
  logic                  busy_q;
  logic                  done_q;
  logic [XLEN-1:0]       hi_q;
  logic [XLEN-1:0]       lo_q;

  logic [XLEN:0]         sum_mul;
  logic [XLEN:0]         rem_sh;
  logic [XLEN:0]         diff;
  logic [2*XLEN-1:0]     prod_res;
  logic [XLEN-1:0]       res_hi;
  logic [XLEN-1:0]       res_lo;
  logic [XLEN-1:0]       abs_a;
  logic [XLEN-1:0]       abs_b;
  logic                  sgn;

  // Operand magnitudes for the op presented at the start port.
  always_comb begin
    sgn   = op_i[0];
    abs_a = (sgn && a_i[XLEN-1]) ? (~a_i + 1'b1) : a_i;
    abs_b = (sgn && b_i[XLEN-1]) ? (~b_i + 1'b1) : b_i;
  end

  // One shift-add or restoring shift-subtract step, and the signed fix-up of its result.
  always_comb begin
    sum_mul = {1'b0, w_q[2*XLEN-1:XLEN]} + (w_q[0] ? {1'b0, m_q} : '0);
    rem_sh  = w_q[2*XLEN-1:XLEN-1];
    diff    = rem_sh - {1'b0, m_q};
    if (is_div_q) begin
      if (diff[XLEN]) w_d = {rem_sh[XLEN-1:0], w_q[XLEN-2:0], 1'b0};
      else            w_d = {diff[XLEN-1:0],   w_q[XLEN-2:0], 1'b1};
    end else begin
      w_d = {sum_mul, w_q[XLEN-1:1]};
    end
    prod_res = neg_lo_q ? (~w_d + 1'b1) : w_d;
    if (is_div_q) begin
      res_lo = neg_lo_q ? (~w_d[XLEN-1:0] + 1'b1) : w_d[XLEN-1:0];
      res_hi = neg_hi_q ? (~w_d[2*XLEN-1:XLEN] + 1'b1) : w_d[2*XLEN-1:XLEN];
    end else begin
      res_lo = prod_res[XLEN-1:0];
      res_hi = prod_res[2*XLEN-1:XLEN];
    end
  end

  // Control FSM with registered busy/done and the HI/LO registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      m_q      <= '0;
      w_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      case (state_q)
        IDLE, FIN: begin
          done_q <= 1'b0;
          // Moves land now; an accepted op overwrites them when it completes.
          if (mthi_i) hi_q <= wdata_i;
          if (mtlo_i) lo_q <= wdata_i;
          if (start_i) begin
            state_q  <= RUN;
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            is_div_q <= op_i[1];
            if (op_i[1]) begin
              m_q      <= abs_b;
              w_q      <= {{XLEN{1'b0}}, abs_a};
              // Divide by zero keeps the all-ones quotient regardless of signs.
              neg_lo_q <= sgn && (a_i[XLEN-1] ^ b_i[XLEN-1]) && (b_i != '0);
              neg_hi_q <= sgn && a_i[XLEN-1];
            end else begin
              m_q      <= abs_a;
              w_q      <= {{XLEN{1'b0}}, abs_b};
              neg_lo_q <= sgn && (a_i[XLEN-1] ^ b_i[XLEN-1]);
              neg_hi_q <= 1'b0;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          w_q   <= w_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_q <= FIN;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            hi_q    <= res_hi;
            lo_q    <= res_lo;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule
